// File: rtl/cipher_bus_mux_if.sv
// Bundle of channel-side and core-side signals for cipher_bus_mux.
// The master modport is the mux's view; slave is the environment's view
// (requesters plus the cipher core).
interface cipher_bus_mux_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 128
);
  logic                     enable;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ende;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_accept;
  logic [NUM_CH-1:0]        ch_res_valid;
  logic [DATA_W-1:0]        res_data;
  logic                     drain_req;
  logic                     drained;
  logic                     err;
  logic                     core_enable;
  logic                     core_ende;
  logic                     core_data_valid;
  logic [DATA_W-1:0]        core_data;
  logic                     core_ready;
  logic                     core_res_valid;
  logic [DATA_W-1:0]        core_res_data;
  logic [31:0]              issue_cnt;
  logic [31:0]              done_cnt;

  modport master (
    input  enable, ch_valid, ch_ende, ch_data, drain_req,
    input  core_ready, core_res_valid, core_res_data,
    output ch_accept, ch_res_valid, res_data, drained, err,
    output core_enable, core_ende, core_data_valid, core_data,
    output issue_cnt, done_cnt
  );

  modport slave (
    output enable, ch_valid, ch_ende, ch_data, drain_req,
    output core_ready, core_res_valid, core_res_data,
    input  ch_accept, ch_res_valid, res_data, drained, err,
    input  core_enable, core_ende, core_data_valid, core_data,
    input  issue_cnt, done_cnt
  );
endinterface

// File: rtl/cipher_bus_mux.sv
// cipher_bus_mux: round-robin front end sharing one AES core among NUM_CH
// requesters. A tag FIFO remembers the owner of each in-flight operation so
// in-order results can be routed back. Drain control and an error flag for
// unexpected results are included.
// Optional statistics counters are enabled with CIPHER_BUS_MUX_STATS_EN.
module cipher_bus_mux #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned MAX_OUT = 8
) (
  input logic              clk,
  input logic              resetH,
  cipher_bus_mux_if.master bus
);

  localparam int unsigned PTR_W = $clog2(MAX_OUT);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {StRun, StDrain} state_t;

  state_t            state_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   tag_mem [MAX_OUT];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              core_data_valid_q;
  logic [DATA_W-1:0] core_data_q;
  logic              core_ende_q;
  logic [NUM_CH-1:0] ch_res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic              err_q;
  logic              drained_q;

  logic              found;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   grant_next;
  logic [CH_W:0]     sum;
  logic [CH_W-1:0]   head;
  logic              issue;
  logic              pop;

  // Round-robin search: first requesting channel at or after rr_ptr_q.
  always_comb begin
    found = 1'b0;
    grant = '0;
    sum   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      if (!found && bus.ch_valid[sum[CH_W-1:0]]) begin
        found = 1'b1;
        grant = sum[CH_W-1:0];
      end
    end
  end

  // Issue/return qualification and the FIFO occupancy update.
  always_comb begin
    // core_data_valid_q in the condition enforces 2-cycle issue spacing
    issue = (state_q == StRun) && bus.enable && bus.core_ready && !core_data_valid_q &&
            (count_q < CNT_W'(MAX_OUT)) && found;
    pop   = bus.core_res_valid && (count_q != '0);
    head  = tag_mem[rd_ptr_q];
    grant_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
    count_d = count_q;
    if (issue && !pop)      count_d = count_q + CNT_W'(1);
    else if (!issue && pop) count_d = count_q - CNT_W'(1);
  end

  // Tag storage; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr_q] <= grant;
  end

  // Main datapath, FIFO pointers, error flag and RUN/DRAIN state machine.
  always_ff @(posedge clk) begin
    if (resetH) begin
      state_q           <= StRun;
      rr_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      core_data_valid_q <= 1'b0;
      core_data_q       <= '0;
      core_ende_q       <= 1'b0;
      ch_res_valid_q    <= '0;
      res_data_q        <= '0;
      err_q             <= 1'b0;
      drained_q         <= 1'b0;
    end else begin
      core_data_valid_q <= issue;
      if (issue) begin
        core_data_q <= bus.ch_data[grant*DATA_W +: DATA_W];
        core_ende_q <= bus.ch_ende[grant];
        rr_ptr_q    <= grant_next;
        wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q       <= rd_ptr_q + PTR_W'(1);
        res_data_q     <= bus.core_res_data;
        ch_res_valid_q <= NUM_CH'(1) << head;
      end else begin
        ch_res_valid_q <= '0;
      end
      count_q <= count_d;
      if (bus.core_res_valid && (count_q == '0)) err_q <= 1'b1;

      unique case (state_q)
        StRun: begin
          drained_q <= 1'b0;
          if (bus.drain_req) state_q <= StDrain;
        end
        StDrain: begin
          if (!bus.drain_req) begin
            state_q   <= StRun;
            drained_q <= 1'b0;
          end else begin
            drained_q <= (count_q == '0);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef CIPHER_BUS_MUX_STATS_EN
  logic [31:0] issue_cnt_q, done_cnt_q;

  // Saturating issue/return statistics.
  always_ff @(posedge clk) begin
    if (resetH) begin
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
    end else begin
      if (issue && (issue_cnt_q != '1)) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (pop && (done_cnt_q != '1))    done_cnt_q  <= done_cnt_q + 32'd1;
    end
  end

  assign bus.issue_cnt = issue_cnt_q;
  assign bus.done_cnt  = done_cnt_q;
`else
  assign bus.issue_cnt = 32'd0;
  assign bus.done_cnt  = 32'd0;
`endif

  assign bus.core_enable     = bus.enable;
  assign bus.ch_accept       = issue ? (NUM_CH'(1) << grant) : '0;
  assign bus.core_data_valid = core_data_valid_q;
  assign bus.core_data       = core_data_q;
  assign bus.core_ende       = core_ende_q;
  assign bus.ch_res_valid    = ch_res_valid_q;
  assign bus.res_data        = res_data_q;
  assign bus.err             = err_q;
  assign bus.drained         = drained_q;

endmodule

// File: tb/tb_cipher_bus_mux.sv
// Directed self-checking bench for cipher_bus_mux (NUM_CH=4, MAX_OUT=8).
module tb_cipher_bus_mux;
  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 128;
  localparam int MAX_OUT = 8;

  logic clk = 1'b0;
  logic resetH;
  always #5 clk = ~clk;

  cipher_bus_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  cipher_bus_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk    (clk),
    .resetH (resetH),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] txt [NUM_CH];
  logic [NUM_CH-1:0] ende_bits = 4'b1010;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One issue of channel g from an eligible cycle; ends on the next eligible cycle.
  task automatic do_issue(input int g);
    #1;
    chk("accept", DATA_W'(bus.ch_accept), DATA_W'(1 << g));
    tick();
    chk("core_data_valid", DATA_W'(bus.core_data_valid), 1);
    chk("core_data", bus.core_data, txt[g]);
    chk("core_ende", DATA_W'(bus.core_ende), DATA_W'(ende_bits[g]));
    chk("spacing_no_accept", DATA_W'(bus.ch_accept), 0);
    tick();
  endtask

  // One core result, expected to be routed to channel h.
  task automatic do_return(input int h, input logic [DATA_W-1:0] r);
    bus.core_res_valid = 1'b1;
    bus.core_res_data  = r;
    tick();
    bus.core_res_valid = 1'b0;
    chk("ch_res_valid", DATA_W'(bus.ch_res_valid), DATA_W'(1 << h));
    chk("res_data", bus.res_data, r);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    txt[0] = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    txt[1] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    txt[2] = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    txt[3] = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
    for (int k = 0; k < NUM_CH; k++) bus.ch_data[k*DATA_W +: DATA_W] = txt[k];
    bus.ch_ende        = ende_bits;
    bus.enable         = 1'b1;
    bus.ch_valid       = '0;
    bus.drain_req      = 1'b0;
    bus.core_ready     = 1'b1;
    bus.core_res_valid = 1'b0;
    bus.core_res_data  = '0;
    resetH             = 1'b1;
    tick();
    tick();
    resetH = 1'b0;

    // Reset values
    chk("rst_core_data_valid", DATA_W'(bus.core_data_valid), 0);
    chk("rst_core_data", bus.core_data, 0);
    chk("rst_core_ende", DATA_W'(bus.core_ende), 0);
    chk("rst_ch_res_valid", DATA_W'(bus.ch_res_valid), 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_err", DATA_W'(bus.err), 0);
    chk("rst_drained", DATA_W'(bus.drained), 0);
    chk("rst_issue_cnt", DATA_W'(bus.issue_cnt), 0);
    chk("rst_done_cnt", DATA_W'(bus.done_cnt), 0);

    // Single-channel issue and return
    bus.ch_valid = 4'b0010;
    do_issue(1);
    bus.ch_valid = 4'b0000;
    do_return(1, 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A);
    tick();
    chk("res_pulse_one_cycle", DATA_W'(bus.ch_res_valid), 0);

    // Fairness from a fresh pointer: grants 0,1,2,3,0
    resetH = 1'b1;
    tick();
    resetH = 1'b0;
    bus.ch_valid = 4'b1111;
    do_issue(0);
    do_issue(1);
    do_issue(2);
    do_issue(3);
    do_issue(0);
    bus.ch_valid = 4'b0000;
    do_return(0, 128'h1);
    do_return(1, 128'h2);
    do_return(2, 128'h3);
    do_return(3, 128'h4);
    do_return(0, 128'h5);
    tick();
    chk("fair_idle_res", DATA_W'(bus.ch_res_valid), 0);
    chk("fair_no_err", DATA_W'(bus.err), 0);

    // Full FIFO: 8 in flight blocks the 9th until one return
    bus.ch_valid = 4'b1111;
    for (int i = 0; i < MAX_OUT; i++) do_issue((1 + i) % NUM_CH);
    #1;
    chk("full_no_accept_a", DATA_W'(bus.ch_accept), 0);
    tick();
    #1;
    chk("full_no_accept_b", DATA_W'(bus.ch_accept), 0);
    bus.core_res_valid = 1'b1;
    bus.core_res_data  = 128'h10;
    #1;
    chk("full_no_accept_on_pop", DATA_W'(bus.ch_accept), 0);
    tick();
    bus.core_res_valid = 1'b0;
    chk("full_first_ret", DATA_W'(bus.ch_res_valid), DATA_W'(4'b0010));
    do_issue(1);
    bus.ch_valid = 4'b0000;
    do_return(2, 128'h11);
    do_return(3, 128'h12);
    do_return(0, 128'h13);
    do_return(1, 128'h14);
    do_return(2, 128'h15);
    do_return(3, 128'h16);
    do_return(0, 128'h17);
    do_return(1, 128'h18);
    tick();
    chk("full_idle_res", DATA_W'(bus.ch_res_valid), 0);

    // Simultaneous push (tag 3) and pop (tag 2)
    bus.ch_valid = 4'b0100;
    do_issue(2);
    bus.ch_valid       = 4'b1000;
    bus.core_res_valid = 1'b1;
    bus.core_res_data  = 128'h20;
    #1;
    chk("pp_accept", DATA_W'(bus.ch_accept), DATA_W'(4'b1000));
    tick();
    bus.ch_valid       = 4'b0000;
    bus.core_res_valid = 1'b0;
    chk("pp_ret_tag2", DATA_W'(bus.ch_res_valid), DATA_W'(4'b0100));
    chk("pp_res_data", bus.res_data, 128'h20);
    chk("pp_issue_data", bus.core_data, txt[3]);
    do_return(3, 128'h21);
    chk("pp_no_err", DATA_W'(bus.err), 0);

    // Drain with 3 in flight, then an unexpected result
    bus.ch_valid = 4'b1111;
    do_issue(0);
    do_issue(1);
    #1;
    chk("dr_accept2", DATA_W'(bus.ch_accept), DATA_W'(4'b0100));
    tick();
    bus.drain_req = 1'b1;
    chk("dr_cdv", DATA_W'(bus.core_data_valid), 1);
    tick();
    chk("dr_no_accept_a", DATA_W'(bus.ch_accept), 0);
    chk("dr_drained_busy_a", DATA_W'(bus.drained), 0);
    tick();
    chk("dr_no_accept_b", DATA_W'(bus.ch_accept), 0);
    chk("dr_drained_busy_b", DATA_W'(bus.drained), 0);
    do_return(0, 128'h30);
    do_return(1, 128'h31);
    do_return(2, 128'h32);
    tick();
    chk("dr_drained", DATA_W'(bus.drained), 1);
    chk("dr_pending_held", DATA_W'(bus.ch_accept), 0);
    bus.core_res_valid = 1'b1;
    tick();
    bus.core_res_valid = 1'b0;
    chk("err_set", DATA_W'(bus.err), 1);
    chk("err_no_res", DATA_W'(bus.ch_res_valid), 0);
    tick();
    chk("err_sticky", DATA_W'(bus.err), 1);
    bus.drain_req = 1'b0;
    tick();
    chk("undrain_drained", DATA_W'(bus.drained), 0);
    do_issue(3);
    bus.ch_valid = 4'b0000;
    do_return(3, 128'h33);
    chk("err_still_sticky", DATA_W'(bus.err), 1);

    // Reset clears error and counters
    resetH = 1'b1;
    tick();
    resetH = 1'b0;
    chk("rst2_err", DATA_W'(bus.err), 0);
    chk("rst2_issue_cnt", DATA_W'(bus.issue_cnt), 0);
    chk("rst2_done_cnt", DATA_W'(bus.done_cnt), 0);

    // Statistics: 5 issues, 5 returns
    bus.ch_valid = 4'b1111;
    for (int i = 0; i < 5; i++) do_issue(i % NUM_CH);
    bus.ch_valid = 4'b0000;
    for (int i = 0; i < 5; i++) do_return(i % NUM_CH, DATA_W'(64 + i));
`ifdef CIPHER_BUS_MUX_STATS_EN
    chk("stats_issue_cnt", DATA_W'(bus.issue_cnt), 5);
    chk("stats_done_cnt", DATA_W'(bus.done_cnt), 5);
`else
    chk("stats_issue_cnt_off", DATA_W'(bus.issue_cnt), 0);
    chk("stats_done_cnt_off", DATA_W'(bus.done_cnt), 0);
`endif
    resetH = 1'b1;
    tick();
    resetH = 1'b0;
    chk("stats_rst_issue", DATA_W'(bus.issue_cnt), 0);
    chk("stats_rst_done", DATA_W'(bus.done_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
